// File: rtl/mod12_counter_ctrl.sv
// -----------------------------------------------------------------------------
// mod12_counter_ctrl
//
// Sequencing controller that sits in front of a mod-12 up/down counter.
// Two requesters submit jobs (start value, direction, step count). The
// controller picks one round-robin, loads the counter, lets it count for
// the requested number of steps, then holds it and reports the result.
//
// Ports:
//   clk, rst_n                  - clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready     - job handshake for requester N (N = 0, 1)
//   reqN_start / dir / steps    - job payload, sampled only on accept
//   cnt_value                   - counter's current count
//   cnt_load / mode / data      - drive the counter's load, mode, data_in
//   busy                        - controller is not idle
//   done_valid/id/value/err     - one-cycle completion report
// -----------------------------------------------------------------------------
module mod12_counter_ctrl #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_start,
    input  logic              req0_dir,
    input  logic [STEP_W-1:0] req0_steps,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_start,
    input  logic              req1_dir,
    input  logic [STEP_W-1:0] req1_steps,
    input  logic [3:0]        cnt_value,
    output logic              cnt_load,
    output logic              cnt_mode,
    output logic [3:0]        cnt_data,
    output logic              busy,
    output logic              done_valid,
    output logic              done_id,
    output logic [3:0]        done_value,
    output logic              done_err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [3:0]        MAX_START = 4'd11;
    localparam logic [STEP_W-1:0] ONE_STEP  = STEP_W'(1);

    state_t              state_q, state_d;
    logic [3:0]          start_q, start_d;
    logic                dir_q, dir_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic                id_q, id_d;
    logic                prio_q, prio_d;
    logic                done_valid_q, done_valid_d;
    logic                done_id_q, done_id_d;
    logic                done_err_q, done_err_d;
    logic [3:0]          done_value_q, done_value_d;

    logic                grant0, grant1, accept;
    logic [3:0]          acc_start;
    logic                acc_dir;
    logic [STEP_W-1:0]   acc_steps;

    // prio_q holds the id granted last; on a tie the other requester wins.
    // Resetting it to 1 lets requester 0 win the first tie.
    always_comb begin
        grant1     = req1_valid && (!req0_valid || !prio_q);
        grant0     = req0_valid && !grant1;
        req0_ready = rst_n && (state_q == IDLE) && grant0;
        req1_ready = rst_n && (state_q == IDLE) && grant1;
        accept     = req0_ready || req1_ready;
        acc_start  = grant1 ? req1_start : req0_start;
        acc_dir    = grant1 ? req1_dir   : req0_dir;
        acc_steps  = grant1 ? req1_steps : req0_steps;
    end

    // The counter has no enable, so outside LOAD and RUN (and during reset)
    // it is held by reloading its own value.
    always_comb begin
        cnt_load = 1'b1;
        cnt_mode = 1'b1;
        cnt_data = cnt_value;
        if (rst_n) begin
            if (state_q == LOAD) begin
                cnt_data = start_q;
            end else if (state_q == RUN) begin
                cnt_load = 1'b0;
                cnt_mode = dir_q;
            end
        end
    end

    // Next-state logic. steps_q doubles as the remaining-step down-counter;
    // RUN leaves when the last step is taken, so the counter advances
    // exactly steps times. Completion flags are set on entry to DONE.
    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        dir_d        = dir_q;
        steps_d      = steps_q;
        id_d         = id_q;
        prio_d       = prio_q;
        done_valid_d = 1'b0;
        done_id_d    = done_id_q;
        done_err_d   = done_err_q;
        done_value_d = done_value_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    start_d = acc_start;
                    dir_d   = acc_dir;
                    steps_d = acc_steps;
                    id_d    = grant1;
                    prio_d  = grant1;
                    if (acc_start > MAX_START) begin
                        state_d      = DONE;
                        done_valid_d = 1'b1;
                        done_id_d    = grant1;
                        done_err_d   = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (steps_q != '0) begin
                    state_d = RUN;
                end else begin
                    state_d      = DONE;
                    done_valid_d = 1'b1;
                    done_id_d    = id_q;
                    done_err_d   = 1'b0;
                end
            end
            RUN: begin
                if (steps_q == ONE_STEP) begin
                    state_d      = DONE;
                    done_valid_d = 1'b1;
                    done_id_d    = id_q;
                    done_err_d   = 1'b0;
                end else begin
                    steps_d = steps_q - ONE_STEP;
                end
            end
            DONE: begin
                state_d      = IDLE;
                done_value_d = cnt_value;
            end
            default: state_d = IDLE;
        endcase
    end

    // Single state/output register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start_q      <= '0;
            dir_q        <= 1'b0;
            steps_q      <= '0;
            id_q         <= 1'b0;
            prio_q       <= 1'b1;
            done_valid_q <= 1'b0;
            done_id_q    <= 1'b0;
            done_err_q   <= 1'b0;
            done_value_q <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            dir_q        <= dir_d;
            steps_q      <= steps_d;
            id_q         <= id_d;
            prio_q       <= prio_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            done_err_q   <= done_err_d;
            done_value_q <= done_value_d;
        end
    end

    // The counter only settles on its final value during DONE, so the
    // reported value is taken live then and the last report is kept after.
    assign done_value = done_valid_q ? cnt_value : done_value_q;
    assign done_valid = done_valid_q;
    assign done_id    = done_id_q;
    assign done_err   = done_err_q;
    assign busy       = (state_q != IDLE);

endmodule
